// File: rtl/clint_responder.sv
// Core-local interruptor: msip / mtimecmp / mtime registers behind the Clint* side bus,
// with registered machine timer and software interrupt lines.
module clint_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
  parameter int unsigned TICK_DIV  = 1,
  parameter logic [63:0] MTIME_RST = 64'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ClintReadEnable,
  input  logic [63:0] ClintReadAddr,
  output logic [63:0] ClintReadData,
  input  logic        ClintWriteEnable,
  input  logic [63:0] ClintWriteAddr,
  input  logic [63:0] ClintWriteData,
  input  logic [63:0] ClintWriteMask,
  output logic        mtip,
  output logic        msip,
  output logic [63:0] mtime_o
);

  localparam logic [63:0] A_MSIP  = BASE_ADDR;
  localparam logic [63:0] A_CMP   = BASE_ADDR + 64'h4000;
  localparam logic [63:0] A_MTIME = BASE_ADDR + 64'hBFF8;
  localparam int          CW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC    = CW'(TICK_DIV - 1);

  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   cmp_q, cmp_d;
  logic          msip_reg_q, msip_reg_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic          mtip_q, msip_q;
  logic          tick;
  logic          wr_msip, wr_cmp, wr_mtime;
  logic          rd_msip, rd_cmp, rd_mtime;

  // Only the dword index is decoded; byte offsets within a dword are ignored.
  assign rd_msip  = ClintReadAddr[63:3]  == A_MSIP[63:3];
  assign rd_cmp   = ClintReadAddr[63:3]  == A_CMP[63:3];
  assign rd_mtime = ClintReadAddr[63:3]  == A_MTIME[63:3];
  assign wr_msip  = ClintWriteEnable && (ClintWriteAddr[63:3] == A_MSIP[63:3]);
  assign wr_cmp   = ClintWriteEnable && (ClintWriteAddr[63:3] == A_CMP[63:3]);
  assign wr_mtime = ClintWriteEnable && (ClintWriteAddr[63:3] == A_MTIME[63:3]);

  assign tick = (tick_cnt_q == TC);

  always_comb begin
    ClintReadData = 64'h0;
    if (ClintReadEnable && !rst) begin
      if (rd_msip)       ClintReadData = {63'h0, msip_reg_q};
      else if (rd_cmp)   ClintReadData = cmp_q;
      else if (rd_mtime) ClintReadData = mtime_q;
    end
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    msip_reg_d = msip_reg_q;
    cmp_d      = cmp_q;
    mtime_d    = mtime_q;
    if (wr_msip)
      msip_reg_d = (msip_reg_q & ~ClintWriteMask[0]) | (ClintWriteData[0] & ClintWriteMask[0]);
    if (wr_cmp)
      cmp_d = (cmp_q & ~ClintWriteMask) | (ClintWriteData & ClintWriteMask);
    // A software write to mtime swallows that cycle's increment.
    if (wr_mtime)
      mtime_d = (mtime_q & ~ClintWriteMask) | (ClintWriteData & ClintWriteMask);
    else if (tick)
      mtime_d = mtime_q + 64'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mtime_q    <= MTIME_RST;
      cmp_q      <= '1;
      msip_reg_q <= 1'b0;
      tick_cnt_q <= '0;
      mtip_q     <= 1'b0;
      msip_q     <= 1'b0;
    end else begin
      mtime_q    <= mtime_d;
      cmp_q      <= cmp_d;
      msip_reg_q <= msip_reg_d;
      tick_cnt_q <= tick_cnt_d;
      mtip_q     <= (mtime_q >= cmp_q);
      msip_q     <= msip_reg_q;
    end
  end

  assign mtip    = mtip_q;
  assign msip    = msip_q;
  assign mtime_o = mtime_q;

  logic unused_bits;
  assign unused_bits = ^{ClintReadAddr[2:0], ClintWriteAddr[2:0],
                         ClintWriteData[63:1], ClintWriteMask[63:1]};

endmodule
